// File: rtl/uart_rx_frame_pkg.sv
// Shared UART receiver definitions: parity modes, default width and FSM state encoding.
package uart_rx_frame_pkg;

    localparam int PARITY_NONE   = 0;
    localparam int PARITY_ODD    = 1;
    localparam int PARITY_EVEN   = 2;
    localparam int DEF_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// RX line synchroniser: SYNC_STAGES flops (reset to idle-high) plus falling-edge detect.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_fall_edge
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign o_rx_s      = sync_q[SYNC_STAGES-1];
    assign o_fall_edge = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: samples the synchronised line at bit centres (odd half pulses)
// and strobes each byte with parity / framing flags.
module uart_rx_frame
    import uart_rx_frame_pkg::*;
#(
    parameter int DATA_BITS   = DEF_DATA_BITS,
    parameter int PARITY_MODE = PARITY_NONE,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx,
    input  logic                 i_half_pulse,
    output logic                 o_div_en,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam logic [4:0] LAST_DATA_HC = 5'(2 * DATA_BITS + 1);

    rx_state_e            state_q, state_d;
    logic [4:0]           hc_q, hc_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 par_err_q, par_err_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_out_q, ferr_out_d;

    logic       rx_s;
    logic       fall_edge;
    logic       div_en;
    logic [4:0] hc_inc;
    logic       samp;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rx        (i_rx),
        .o_rx_s      (rx_s),
        .o_fall_edge (fall_edge)
    );

    assign div_en = (state_q != ST_IDLE);
    assign hc_inc = hc_q + 5'd1;
    // Odd half-pulse counts land on bit centres.
    assign samp   = i_half_pulse & hc_inc[0];

    always_comb begin
        state_d    = state_q;
        hc_d       = hc_q;
        sh_d       = sh_q;
        par_err_d  = par_err_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;

        if (div_en && i_half_pulse) hc_d = hc_inc;

        case (state_q)
            ST_IDLE: begin
                if (fall_edge) begin
                    state_d   = ST_START;
                    hc_d      = 5'd0;
                    par_err_d = 1'b0;
                end
            end
            ST_START: begin
                if (samp) state_d = rx_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (samp) begin
                    sh_d = {rx_s, sh_q[DATA_BITS-1:1]};
                    if (hc_inc == LAST_DATA_HC)
                        state_d = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (samp) begin
                    par_err_d = (PARITY_MODE == PARITY_ODD) ? ~(^sh_q ^ rx_s) : (^sh_q ^ rx_s);
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (samp) begin
                    data_d     = sh_q;
                    valid_d    = 1'b1;
                    perr_out_d = par_err_q;
                    ferr_out_d = ~rx_s;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            hc_q       <= '0;
            sh_q       <= '0;
            par_err_q  <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hc_q       <= hc_d;
            sh_q       <= sh_d;
            par_err_q  <= par_err_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
        end
    end

    assign o_div_en     = div_en;
    assign o_busy       = div_en;
    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_parity_err = perr_out_q;
    assign o_frame_err  = ferr_out_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: a no-parity and an even-parity receiver, each fed by a
// half-bit divider model (4 clocks per half bit), checked against a frame-level model.
module tb_uart_rx_frame;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       f;
        logic       idle;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic       rx0, rx2;
    logic       hp0, hp2;
    logic       den0, den2;
    logic [7:0] data0, data2;
    logic       v0, v2, pe0, pe2, fe0, fe2, busy0, busy2;
    logic [1:0] dcnt0, dcnt2;

    obs_t q0[$];
    obs_t q2[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_rx_frame #(.DATA_BITS(8), .PARITY_MODE(0), .SYNC_STAGES(2)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx0), .i_half_pulse(hp0), .o_div_en(den0),
        .o_data(data0), .o_valid(v0), .o_parity_err(pe0), .o_frame_err(fe0), .o_busy(busy0)
    );

    uart_rx_frame #(.DATA_BITS(8), .PARITY_MODE(2), .SYNC_STAGES(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx2), .i_half_pulse(hp2), .o_div_en(den2),
        .o_data(data2), .o_valid(v2), .o_parity_err(pe2), .o_frame_err(fe2), .o_busy(busy2)
    );

    // Divider model: counter held at 0 while disabled, pulse every 4th enabled clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt0 <= 2'd0;
            dcnt2 <= 2'd0;
        end else begin
            dcnt0 <= den0 ? dcnt0 + 2'd1 : 2'd0;
            dcnt2 <= den2 ? dcnt2 + 2'd1 : 2'd0;
        end
    end
    assign hp0 = den0 && (dcnt0 == 2'd3);
    assign hp2 = den2 && (dcnt2 == 2'd3);

    always @(negedge clk) begin
        if (v0) q0.push_back(obs_t'{data0, pe0, fe0, !den0 && !busy0});
        if (v2) q2.push_back(obs_t'{data2, pe2, fe2, !den2 && !busy2});
    end

    // Reference: a frame is its data byte; even parity flags an odd count of ones
    // over data plus parity bit; a low stop bit is a framing error.
    function automatic obs_t model(input logic [7:0] d, input bit par_en,
                                   input logic pbit, input logic stop);
        obs_t e;
        e.d    = d;
        e.p    = par_en ? ((($countones(d) + int'(pbit)) % 2) != 0) : 1'b0;
        e.f    = !stop;
        e.idle = 1'b1;
        return e;
    endfunction

    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) rx0 = v;
        else          rx2 = v;
    endtask

    task automatic send_bit(input int sel, input logic v);
        set_rx(sel, v);
        repeat (8) @(negedge clk);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input bit has_par,
                              input logic pbit, input logic stop);
        send_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
        if (has_par) send_bit(sel, pbit);
        send_bit(sel, stop);
    endtask

    task automatic idle(input int sel, input int cycles);
        set_rx(sel, 1'b1);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic wait_obs(input int sel, input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if ((sel == 0 ? q0.size() : q2.size()) >= n) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic pop_obs(input int sel, output obs_t o);
        if (sel == 0) o = q0.pop_front();
        else          o = q2.pop_front();
    endtask

    task automatic test_reset;
        n_cmp++; if ({v0, pe0, fe0, den0, busy0} !== 5'b0) begin n_bad++;
            $display("FAIL reset_flags0 got=%b want=00000", {v0, pe0, fe0, den0, busy0}); end
        n_cmp++; if (data0 !== 8'h00) begin n_bad++;
            $display("FAIL reset_data0 got=%h want=00", data0); end
        n_cmp++; if ({v2, pe2, fe2, den2, busy2} !== 5'b0) begin n_bad++;
            $display("FAIL reset_flags2 got=%b want=00000", {v2, pe2, fe2, den2, busy2}); end
        n_cmp++; if (data2 !== 8'h00) begin n_bad++;
            $display("FAIL reset_data2 got=%h want=00", data2); end
    endtask

    task automatic test_basic;
        obs_t o, e;
        bit ok;
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        idle(0, 16);
        wait_obs(0, 1, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL basic_timeout got=no_strobe want=strobe"); end
        else begin
            pop_obs(0, o);
            e = model(8'hA5, 1'b0, 1'b0, 1'b1);
            n_cmp++; if (o !== e) begin n_bad++;
                $display("FAIL basic_A5 got=%h want=%h", o, e); end
            n_cmp++; if (q0.size() != 0) begin n_bad++;
                $display("FAIL basic_extra got=%0d want=0", q0.size()); end
        end
    endtask

    task automatic test_glitch;
        set_rx(0, 1'b0);
        repeat (2) @(negedge clk);
        set_rx(0, 1'b1);
        repeat (3) @(negedge clk);
        n_cmp++; if (busy0 !== 1'b1) begin n_bad++;
            $display("FAIL glitch_busy_hi got=%b want=1", busy0); end
        repeat (30) @(negedge clk);
        n_cmp++; if (busy0 !== 1'b0 || den0 !== 1'b0) begin n_bad++;
            $display("FAIL glitch_idle got=%b%b want=00", busy0, den0); end
        n_cmp++; if (q0.size() != 0) begin n_bad++;
            $display("FAIL glitch_strobe got=%0d want=0", q0.size()); end
    endtask

    task automatic test_framing;
        obs_t o, e;
        bit ok;
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        idle(0, 16);
        wait_obs(0, 1, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL framing_timeout got=no_strobe want=strobe"); end
        else begin
            pop_obs(0, o);
            e = model(8'h3C, 1'b0, 1'b0, 1'b0);
            n_cmp++; if (o !== e) begin n_bad++;
                $display("FAIL framing_3C got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_break;
        obs_t o, e;
        bit ok;
        set_rx(0, 1'b0);
        repeat (160) @(negedge clk);
        wait_obs(0, 1, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL break_timeout got=no_strobe want=strobe"); end
        else begin
            pop_obs(0, o);
            e = model(8'h00, 1'b0, 1'b0, 1'b0);
            n_cmp++; if (o !== e) begin n_bad++;
                $display("FAIL break_frame got=%h want=%h", o, e); end
        end
        n_cmp++; if (busy0 !== 1'b0 || q0.size() != 0) begin n_bad++;
            $display("FAIL break_restart got=busy%b/q%0d want=busy0/q0", busy0, q0.size()); end
        idle(0, 16);
    endtask

    task automatic test_parity;
        obs_t o, e;
        bit ok;
        for (int k = 0; k < 2; k++) begin
            logic pb;
            pb = (k == 0);
            send_frame(2, 8'h07, 1'b1, pb, 1'b1);
            idle(2, 16);
            wait_obs(2, 1, ok);
            n_cmp++;
            if (!ok) begin n_bad++; $display("FAIL parity_timeout got=no_strobe want=strobe pb=%b", pb); end
            else begin
                pop_obs(2, o);
                e = model(8'h07, 1'b1, pb, 1'b1);
                n_cmp++; if (o !== e) begin n_bad++;
                    $display("FAIL parity_07 pb=%b got=%h want=%h", pb, o, e); end
            end
        end
    endtask

    task automatic test_back_to_back;
        obs_t o, e;
        bit ok;
        logic [7:0] bytes [3];
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55;
        for (int i = 0; i < 3; i++) send_frame(0, bytes[i], 1'b0, 1'b0, 1'b1);
        idle(0, 16);
        wait_obs(0, 3, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL b2b_timeout got=%0d want=3", q0.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                pop_obs(0, o);
                e = model(bytes[i], 1'b0, 1'b0, 1'b1);
                n_cmp++; if (o !== e) begin n_bad++;
                    $display("FAIL b2b_%0d got=%h want=%h", i, o, e); end
            end
        end
    endtask

    task automatic test_reset_mid;
        obs_t o, e;
        bit ok;
        logic [7:0] d;
        d = 8'h81;
        send_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(0, d[i]);
        set_rx(0, d[4]);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        set_rx(0, 1'b1);
        @(negedge clk);
        n_cmp++; if ({v0, pe0, fe0, den0, busy0} !== 5'b0) begin n_bad++;
            $display("FAIL midrst_flags got=%b want=00000", {v0, pe0, fe0, den0, busy0}); end
        n_cmp++; if (data0 !== 8'h00) begin n_bad++;
            $display("FAIL midrst_data got=%h want=00", data0); end
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        n_cmp++; if (q0.size() != 0) begin n_bad++;
            $display("FAIL midrst_strobe got=%0d want=0", q0.size()); end
        send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1);
        idle(0, 16);
        wait_obs(0, 1, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL midrst_timeout got=no_strobe want=strobe"); end
        else begin
            pop_obs(0, o);
            e = model(8'h12, 1'b0, 1'b0, 1'b1);
            n_cmp++; if (o !== e) begin n_bad++;
                $display("FAIL midrst_12 got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_random;
        obs_t o, e;
        bit ok;
        for (int k = 0; k < 16; k++) begin
            int         sel;
            logic [7:0] d;
            logic       pb, st;
            sel = (k < 8) ? 0 : 2;
            d   = 8'($urandom_range(0, 255));
            pb  = 1'($urandom_range(0, 1));
            st  = ($urandom_range(0, 3) != 0);
            send_frame(sel, d, sel == 2, pb, st);
            idle(sel, 8);
            wait_obs(sel, 1, ok);
            n_cmp++;
            if (!ok) begin n_bad++; $display("FAIL rand_timeout k=%0d got=no_strobe want=strobe", k); end
            else begin
                pop_obs(sel, o);
                e = model(d, sel == 2, pb, st);
                n_cmp++; if (o !== e) begin n_bad++;
                    $display("FAIL rand_%0d got=%h want=%h", k, o, e); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rx0   = 1'b1;
        rx2   = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        test_basic();
        test_glitch();
        test_framing();
        test_break();
        test_parity();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
